qeciphy_rx_traffic_checker: RTL and testbench

- Receive-side checker for the incrementing-count traffic that the example-design generator drives into QECIPHY TX.
- Consumes the QECIPHY RX AXI-Stream and locks onto the count sequence with a search/lock state machine.
- Counts mismatches and checked beats, and reports lock and error status for ILA/LED debug.
- Replaces single-bit sticky compare logic with a checker that tolerates start-up offset and recovers after link loss.

---
 rtl/qeciphy_rx_traffic_checker.sv | 133 +++++++++++++
 tb/tb_qeciphy_rx_traffic_checker.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/qeciphy_rx_traffic_checker.sv
// Receive-side checker for the incrementing-count traffic pattern.
// Locks onto the count sequence with a SEARCH/LOCKED state machine, then
// counts checked beats and mismatches (both saturating) for debug visibility.
module qeciphy_rx_traffic_checker #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned LOSS_COUNT = 4,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  ACLK,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    output logic [1:0]            state,
    output logic                  locked,
    output logic                  error_flag,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic [CNT_WIDTH-1:0]  beat_count
);

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_SEARCH = 2'b01;
    localparam logic [1:0] ST_LOCKED = 2'b10;

    logic [DATA_WIDTH-1:0] expected, expected_n;
    logic [7:0]            match_cnt, match_n, match_inc;
    logic [7:0]            miss_cnt, miss_n, miss_inc;
    logic [1:0]            state_n;
    logic [CNT_WIDTH-1:0]  err_n, beat_n;
    logic                  flag_n;
    logic                  accept;
    logic                  hit;

    assign accept = s_tvalid && s_tready;
    assign hit    = (s_tdata == expected);

    // Next-state and next-counter computation for one accepted (or idle) cycle
    always_comb begin
        state_n    = state;
        expected_n = expected;
        match_n    = match_cnt;
        miss_n     = miss_cnt;
        match_inc  = '0;
        miss_inc   = '0;
        err_n      = err_count;
        beat_n     = beat_count;
        flag_n     = error_flag;

        if (state == ST_IDLE) begin
            match_n = '0;
            miss_n  = '0;
        end

        if (!enable) begin
            // Disabled: drop to IDLE and ignore any beat in this cycle
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_n = ST_SEARCH;
                end
                ST_SEARCH: begin
                    if (accept) begin
                        match_inc  = (hit && (match_cnt != 8'd0)) ? match_cnt + 8'd1 : 8'd1;
                        match_n    = match_inc;
                        expected_n = s_tdata + DATA_WIDTH'(1);
                        if (match_inc == 8'(LOCK_COUNT)) begin
                            state_n = ST_LOCKED;
                            miss_n  = '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (accept) begin
                        // Expected advances even on a miss so a single bad word costs one error
                        expected_n = expected + DATA_WIDTH'(1);
                        beat_n     = (beat_count == '1) ? beat_count : beat_count + CNT_WIDTH'(1);
                        if (hit) begin
                            miss_n = '0;
                        end else begin
                            err_n    = (err_count == '1) ? err_count : err_count + CNT_WIDTH'(1);
                            flag_n   = 1'b1;
                            miss_inc = miss_cnt + 8'd1;
                            miss_n   = miss_inc;
                            if (miss_inc == 8'(LOSS_COUNT)) begin
                                state_n = ST_SEARCH;
                                match_n = '0;
                            end
                        end
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end

        if (clear) begin
            err_n  = '0;
            beat_n = '0;
            flag_n = 1'b0;
        end
    end

    // State, counters and registered status outputs
    always_ff @(posedge ACLK or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            s_tready   <= 1'b0;
            locked     <= 1'b0;
            error_flag <= 1'b0;
            err_count  <= '0;
            beat_count <= '0;
            expected   <= '0;
            match_cnt  <= '0;
            miss_cnt   <= '0;
        end else begin
            state      <= state_n;
            s_tready   <= 1'b1;
            locked     <= (state_n == ST_LOCKED);
            error_flag <= flag_n;
            err_count  <= err_n;
            beat_count <= beat_n;
            expected   <= expected_n;
            match_cnt  <= match_n;
            miss_cnt   <= miss_n;
        end
    end

endmodule

// File: tb/tb_qeciphy_rx_traffic_checker.sv
// Directed self-checking bench for qeciphy_rx_traffic_checker.
// Counters are narrowed to 4 bits so saturation is reachable in a short run.
module tb_qeciphy_rx_traffic_checker;

    localparam int unsigned DW = 64;
    localparam int unsigned CW = 4;

    logic          ACLK;
    logic          rst_n;
    logic          enable;
    logic          clear;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tready;
    logic [1:0]    state;
    logic          locked;
    logic          error_flag;
    logic [CW-1:0] err_count;
    logic [CW-1:0] beat_count;

    int unsigned errors = 0;
    int unsigned checks = 0;

    qeciphy_rx_traffic_checker #(
        .DATA_WIDTH (DW),
        .LOCK_COUNT (4),
        .LOSS_COUNT (4),
        .CNT_WIDTH  (CW)
    ) dut (
        .ACLK       (ACLK),
        .rst_n      (rst_n),
        .enable     (enable),
        .clear      (clear),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .state      (state),
        .locked     (locked),
        .error_flag (error_flag),
        .err_count  (err_count),
        .beat_count (beat_count)
    );

    // Free-running clock
    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check the full status bundle
    task automatic chk_all(input string tag, input logic [1:0] st, input logic lk,
                           input logic fl, input logic [CW-1:0] ec, input logic [CW-1:0] bc);
        chk({tag, ".state"},      64'(state),      64'(st));
        chk({tag, ".locked"},     64'(locked),     64'(lk));
        chk({tag, ".error_flag"}, 64'(error_flag), 64'(fl));
        chk({tag, ".err_count"},  64'(err_count),  64'(ec));
        chk({tag, ".beat_count"}, 64'(beat_count), 64'(bc));
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d);
        s_tvalid = 1'b1;
        s_tdata  = d;
        tick();
        s_tvalid = 1'b0;
    endtask

    task automatic send_gap(input logic [DW-1:0] d);
        repeat ($urandom_range(0, 2)) tick();
        send(d);
    endtask

    initial begin
        logic [DW-1:0] e;
        rst_n    = 1'b0;
        enable   = 1'b0;
        clear    = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        #2;
        chk_all("reset", 2'b00, 1'b0, 1'b0, 4'd0, 4'd0);
        chk("reset.tready", 64'(s_tready), 64'd0);
        repeat (3) tick();

        // Release reset with enable high: first edge enters SEARCH and raises ready
        rst_n  = 1'b1;
        enable = 1'b1;
        tick();
        chk("search.state", 64'(state), 64'd1);
        chk("search.tready", 64'(s_tready), 64'd1);

        // Lock on 0x10..0x13
        send(64'h10); send(64'h11); send(64'h12);
        chk("prelock.locked", 64'(locked), 64'd0);
        send(64'h13);
        chk_all("lock", 2'b10, 1'b1, 1'b0, 4'd0, 4'd0);
        for (int i = 'h14; i <= 'h19; i++) send(64'(i));
        chk_all("ten_beats", 2'b10, 1'b1, 1'b0, 4'd0, 4'd6);

        // Single corrupted word: exactly one error, next word matches
        for (int i = 'h1A; i <= 'h1F; i++) send(64'(i));
        send(64'hDEAD);
        chk_all("corrupt", 2'b10, 1'b1, 1'b1, 4'd1, 4'd13);
        send(64'h21);
        chk_all("after_corrupt", 2'b10, 1'b1, 1'b1, 4'd1, 4'd14);

        // Plain clear pulse
        clear = 1'b1; tick(); clear = 1'b0;
        chk_all("clear", 2'b10, 1'b1, 1'b0, 4'd0, 4'd0);

        // Four consecutive bad words drop the lock
        send(64'hBAD0); send(64'hBAD1); send(64'hBAD2);
        chk_all("three_bad", 2'b10, 1'b1, 1'b1, 4'd3, 4'd3);
        send(64'hBAD3);
        chk_all("loss", 2'b01, 1'b0, 1'b1, 4'd4, 4'd4);
        send(64'h500); send(64'h501); send(64'h502); send(64'h503);
        chk_all("relock", 2'b10, 1'b1, 1'b1, 4'd4, 4'd4);

        // Wrap through all-ones into zero
        enable = 1'b0; tick();
        chk_all("disable_idle", 2'b00, 1'b0, 1'b1, 4'd4, 4'd4);
        enable = 1'b1; clear = 1'b1; tick(); clear = 1'b0;
        chk_all("reenable", 2'b01, 1'b0, 1'b0, 4'd0, 4'd0);
        for (int i = 6; i >= 3; i--) send(~64'(i - 1));
        chk("wrap_lock.locked", 64'(locked), 64'd1);
        send(64'hFFFF_FFFF_FFFF_FFFE); send(64'hFFFF_FFFF_FFFF_FFFF);
        send(64'h0); send(64'h1);
        chk_all("wrap", 2'b10, 1'b1, 1'b0, 4'd0, 4'd4);

        // Same wrap sequence with valid gaps
        enable = 1'b0; tick();
        enable = 1'b1; clear = 1'b1; tick(); clear = 1'b0;
        for (int i = 6; i >= 3; i--) send_gap(~64'(i - 1));
        send_gap(64'hFFFF_FFFF_FFFF_FFFE); send_gap(64'hFFFF_FFFF_FFFF_FFFF);
        send_gap(64'h0); send_gap(64'h1);
        repeat (2) tick();
        chk_all("wrap_gaps", 2'b10, 1'b1, 1'b0, 4'd0, 4'd4);

        // clear wins over a same-cycle mismatch
        clear = 1'b1; send(64'h77); clear = 1'b0;
        chk_all("clear_vs_miss", 2'b10, 1'b1, 1'b0, 4'd0, 4'd0);
        send(64'h3);
        chk_all("post_clear_match", 2'b10, 1'b1, 1'b0, 4'd0, 4'd1);

        // Saturation: alternate bad/good so the lock holds
        e = 64'h4;
        for (int i = 0; i < 15; i++) begin
            send(64'hBAD);
            send(e + 64'd1);
            e = e + 64'd2;
        end
        chk_all("sat_reach", 2'b10, 1'b1, 1'b1, 4'hF, 4'hF);
        send(64'hBAD);
        chk_all("sat_hold", 2'b10, 1'b1, 1'b1, 4'hF, 4'hF);

        // Asynchronous reset mid-LOCKED
        #3;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 2'b00, 1'b0, 1'b0, 4'd0, 4'd0);
        chk("async_rst.tready", 64'(s_tready), 64'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("rst_search.state", 64'(state), 64'd1);
        send(64'h700); send(64'h701); send(64'h702); send(64'h703);
        send(64'h1);
        chk_all("rst_relock", 2'b10, 1'b1, 1'b1, 4'd1, 4'd1);

        // enable=0 while locked: IDLE next cycle, beats ignored, counts held
        enable = 1'b0;
        send(64'h2);
        chk_all("en0", 2'b00, 1'b0, 1'b1, 4'd1, 4'd1);
        send(64'h3); send(64'h9);
        chk_all("en0_hold", 2'b00, 1'b0, 1'b1, 4'd1, 4'd1);
        chk("en0.tready", 64'(s_tready), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
